// File: rtl/la_capture_if.sv
// Capture-to-FIFO write port.
//   fifo_data    sample word written into the capture FIFO
//   fifo_push_n  active-low, one-cycle write strobe
//   full_fifo    FIFO full flag returned by the FIFO
// master: capture stage (drives data/strobe). slave: FIFO side.
interface la_capture_if #(
   parameter int DATA_LEN = 32
);
   logic [DATA_LEN-1:0] fifo_data;
   logic                fifo_push_n;
   logic                full_fifo;

   modport master (
      output fifo_data,
      output fifo_push_n,
      input  full_fifo
   );

   modport slave (
      input  fifo_data,
      input  fifo_push_n,
      output full_fifo
   );
endinterface

// File: rtl/la_capture.sv
// Probe capture stage of the logic analyzer.
// Synchronises the probe bus, decimates it with a programmable divider,
// waits for a trigger and pushes samples into the capture FIFO. Samples
// that hit a full FIFO are dropped and counted.
//
// Ports:
//   clk          sampling clock, rising edge
//   rst_n        asynchronous active-low reset
//   run_en       capture enable (START/STOP)
//   probe_in     asynchronous probe pins
//   sample_div   strobe every sample_div+1 clocks
//   capture_len  samples to capture after trigger, 0 = continuous
//   trig_mode    0 immediate, 1 level, 2 edge, 3 immediate
//   trig_mask    bits participating in the trigger
//   trig_value   level-match value
//   fifo_if      FIFO write port (data, push strobe, full flag)
//   overflow     sticky, set on first dropped sample
//   drop_cnt     dropped-sample count, saturating
//   triggered    high from trigger until return to IDLE
//   done         high in DONE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | stopped; divider, sample count and prev_valid held clear
// S_ARMED   | config latched; evaluating trigger on each strobe
// S_CAPTURE | pushing one sample per strobe
// S_DONE    | capture_len samples taken; waiting for run_en low
module la_capture #(
   parameter int DATA_LEN = 32,
   parameter int DIV_LEN  = 16,
   parameter int CNT_LEN  = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run_en,
   input  logic [DATA_LEN-1:0] probe_in,
   input  logic [DIV_LEN-1:0]  sample_div,
   input  logic [CNT_LEN-1:0]  capture_len,
   input  logic [1:0]          trig_mode,
   input  logic [DATA_LEN-1:0] trig_mask,
   input  logic [DATA_LEN-1:0] trig_value,
   la_capture_if.master        fifo_if,
   output logic                overflow,
   output logic [15:0]         drop_cnt,
   output logic                triggered,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [DATA_LEN-1:0] sync1, sync2, prev;
   logic                prev_valid;
   logic [DIV_LEN-1:0]  div_cnt, cfg_div;
   logic [CNT_LEN-1:0]  smp_cnt, cfg_len, smp_cnt_inc;
   logic [1:0]          cfg_mode;
   logic [DATA_LEN-1:0] cfg_mask, cfg_value;
   logic                arm_go, active, strobe, trig_hit, take, take_last;

   assign arm_go      = (state == S_IDLE) && run_en;
   // Strobes are suppressed in the cycle run_en drops so an abort never
   // issues a new push.
   assign active      = ((state == S_ARMED) || (state == S_CAPTURE)) && run_en;
   assign strobe      = active && (div_cnt == '0);
   assign smp_cnt_inc = smp_cnt + CNT_LEN'(1);

   always_comb begin
      trig_hit = 1'b1;
      case (cfg_mode)
         2'd1:    trig_hit = ((sync2 ^ cfg_value) & cfg_mask) == '0;
         2'd2:    trig_hit = prev_valid && (((sync2 ^ prev) & cfg_mask) != '0);
         default: trig_hit = 1'b1;
      endcase
   end

   // The triggering sample is itself the first captured sample.
   assign take      = strobe && ((state == S_CAPTURE) ||
                                 ((state == S_ARMED) && trig_hit));
   assign take_last = take && (cfg_len != '0) && (smp_cnt_inc == cfg_len);

   // Probe synchroniser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= probe_in;
         sync2 <= sync1;
      end
   end

   // Configuration snapshot, taken only when arming
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_div   <= '0;
         cfg_len   <= '0;
         cfg_mode  <= '0;
         cfg_mask  <= '0;
         cfg_value <= '0;
      end else if (arm_go) begin
         cfg_div   <= sample_div;
         cfg_len   <= capture_len;
         cfg_mode  <= trig_mode;
         cfg_mask  <= trig_mask;
         cfg_value <= trig_value;
      end
   end

   // Sample divider: loaded with sample_div on arming so the first strobe
   // lands sample_div+1 clocks into ARMED.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (state == S_IDLE) begin
         div_cnt <= arm_go ? sample_div : '0;
      end else if (!run_en) begin
         div_cnt <= '0;
      end else if (div_cnt == '0) begin
         div_cnt <= cfg_div;
      end else begin
         div_cnt <= div_cnt - DIV_LEN'(1);
      end
   end

   // Captured-sample count; wraps freely in continuous mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_cnt <= '0;
      end else if ((state == S_IDLE) || !run_en) begin
         smp_cnt <= '0;
      end else if (take) begin
         smp_cnt <= smp_cnt_inc;
      end
   end

   // Previous-sample register for edge trigger
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev       <= '0;
         prev_valid <= 1'b0;
      end else if ((state == S_IDLE) || !run_en) begin
         prev_valid <= 1'b0;
      end else if (strobe && (state == S_ARMED) && !trig_hit) begin
         prev       <= sync2;
         prev_valid <= 1'b1;
      end
   end

   // FIFO write port; full_fifo is judged in the strobe cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_if.fifo_data   <= '0;
         fifo_if.fifo_push_n <= 1'b1;
      end else begin
         fifo_if.fifo_push_n <= !(take && !fifo_if.full_fifo);
         if (take && !fifo_if.full_fifo) begin
            fifo_if.fifo_data <= sync2;
         end
      end
   end

   // Drop accounting; kept through DONE/IDLE, cleared on re-arm
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (arm_go) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (take && fifo_if.full_fifo) begin
         overflow <= 1'b1;
         if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!run_en) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    state_nxt = S_ARMED;
            S_ARMED:   if (take) state_nxt = take_last ? S_DONE : S_CAPTURE;
            S_CAPTURE: if (take_last) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_DONE;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      triggered = 1'b0;
      done      = 1'b0;
      case (state)
         S_CAPTURE: triggered = 1'b1;
         S_DONE: begin
            triggered = 1'b1;
            done      = 1'b1;
         end
         default: begin
            triggered = 1'b0;
            done      = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_la_capture.sv
module tb_la_capture;
   localparam int MAXE = 400;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run_en;
   logic [31:0] probe_in;
   logic [15:0] sample_div;
   logic [23:0] capture_len;
   logic [1:0]  trig_mode;
   logic [31:0] trig_mask, trig_value;
   logic        overflow, triggered, done;
   logic [15:0] drop_cnt;

   la_capture_if #(.DATA_LEN(32)) fifo_bus ();

   la_capture dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run_en      (run_en),
      .probe_in    (probe_in),
      .sample_div  (sample_div),
      .capture_len (capture_len),
      .trig_mode   (trig_mode),
      .trig_mask   (trig_mask),
      .trig_value  (trig_value),
      .fifo_if     (fifo_bus),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt),
      .triggered   (triggered),
      .done        (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Per-edge stimulus and expectations. Edge e is the e-th rising edge of a
   // scenario; arming happens at edge 1, strobes at edges 1+k*(div+1), and a
   // strobe at edge e sees the probe value presented at edge e-2.
   logic [31:0] probe_a  [0:MAXE];
   bit          full_a   [0:MAXE];
   bit          run_a    [0:MAXE];
   logic [31:0] exp_data [0:MAXE];
   bit          exp_pushn[0:MAXE];
   bit          exp_trig [0:MAXE];
   bit          exp_done [0:MAXE];
   int          exp_drop [0:MAXE];

   logic [31:0] g_data  = '0;
   int          g_drops = 0;

   task automatic chk_reset_vals(input string tag);
      chk({tag, " push_n"}, 32'(fifo_bus.fifo_push_n), 32'd1);
      chk({tag, " data"},   fifo_bus.fifo_data,        32'd0);
      chk({tag, " ovf"},    32'(overflow),             32'd0);
      chk({tag, " drop"},   32'(drop_cnt),             32'd0);
      chk({tag, " trig"},   32'(triggered),            32'd0);
      chk({tag, " done"},   32'(done),                 32'd0);
   endtask

   task automatic run_scn(input int id, input logic [1:0] mode, input logic [31:0] mask,
                          input logic [31:0] val, input int div, input int len,
                          input int nedge, input int abort_e, input int rst_e);
      logic [31:0] s, pr, cur;
      bit pv, capt, fin, dead, hit, reset_hit;
      int n, drops, npush_exp, npush_obs;
      string t;

      for (int e = 0; e <= nedge; e++) run_a[e] = (e >= 1) && (e < abort_e);

      cur = g_data; drops = g_drops; pr = '0; pv = 0; capt = 0; fin = 0; dead = 0;
      n = 0; npush_exp = 0; hit = 0;
      for (int e = 0; e <= nedge; e++) begin
         exp_pushn[e] = 1;
         if (e == 1) begin
            drops = 0;
         end else if (e >= 2 && !dead) begin
            if (!run_a[e]) begin
               dead = 1; capt = 0; fin = 0;
            end else if (((e - 1) % (div + 1)) == 0 && !fin) begin
               s = probe_a[e-2];
               if (!capt) begin
                  case (mode)
                     2'd1:    hit = ((s ^ val) & mask) == 32'd0;
                     2'd2:    hit = pv && (((s ^ pr) & mask) != 32'd0);
                     default: hit = 1;
                  endcase
                  if (hit) capt = 1;
                  else begin pr = s; pv = 1; end
               end
               if (capt) begin
                  n++;
                  if (full_a[e]) begin
                     if (drops < 65535) drops++;
                  end else begin
                     exp_pushn[e] = 0; cur = s; npush_exp++;
                  end
                  if (len != 0 && n == len) begin capt = 0; fin = 1; end
               end
            end
         end
         exp_data[e] = cur;
         exp_trig[e] = capt || fin;
         exp_done[e] = fin;
         exp_drop[e] = drops;
      end

      npush_obs = 0; reset_hit = 0;
      for (int e = 0; e <= nedge; e++) begin
         run_en = run_a[e];
         probe_in = probe_a[e];
         fifo_bus.full_fifo = full_a[e];
         if (e <= 1) begin
            trig_mode = mode; trig_mask = mask; trig_value = val;
            sample_div = 16'(div); capture_len = 24'(len);
         end else begin
            trig_mode = 2'($urandom); trig_mask = $urandom; trig_value = $urandom;
            sample_div = 16'($urandom); capture_len = 24'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         t = $sformatf("s%0d e%0d", id, e);
         chk({t, " push_n"}, 32'(fifo_bus.fifo_push_n), 32'(exp_pushn[e]));
         chk({t, " data"},   fifo_bus.fifo_data,        exp_data[e]);
         chk({t, " trig"},   32'(triggered),            32'(exp_trig[e]));
         chk({t, " done"},   32'(done),                 32'(exp_done[e]));
         chk({t, " drop"},   32'(drop_cnt),             32'(exp_drop[e]));
         chk({t, " ovf"},    32'(overflow),             32'(exp_drop[e] != 0));
         if (fifo_bus.fifo_push_n == 1'b0) npush_obs++;
         if (e == rst_e) begin
            #1 rst_n = 1'b0;
            #1;
            chk_reset_vals($sformatf("s%0d async_rst", id));
            @(negedge clk);
            run_en = 1'b0;
            rst_n = 1'b1;
            g_data = '0; g_drops = 0; reset_hit = 1;
            break;
         end
      end
      if (!reset_hit) begin
         chk($sformatf("s%0d npush", id), 32'(npush_obs), 32'(npush_exp));
         g_data = exp_data[nedge];
         g_drops = exp_drop[nedge];
      end
   endtask

   function automatic logic [31:0] sym();
      return 32'($urandom_range(0, 3)) * 32'h01010101;
   endfunction

   initial begin
      int div, len, ne;
      logic [31:0] m, v;
      rst_n = 1'b0; run_en = 1'b0; probe_in = '0; sample_div = '0; capture_len = '0;
      trig_mode = '0; trig_mask = '0; trig_value = '0; fifo_bus.full_fifo = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Immediate, counting probe bus
      for (int e = 0; e <= MAXE; e++) begin probe_a[e] = 32'h1000 + 32'(e); full_a[e] = 0; end
      run_scn(1, 2'd0, 32'h0, 32'h0, 0, 4, 20, 18, -1);

      // Level trigger with decimation, low byte ramps through A5
      for (int e = 0; e <= MAXE; e++) begin
         probe_a[e] = {24'($urandom), 8'(8'hA0 + e / 4)};
         full_a[e] = 0;
      end
      run_scn(2, 2'd1, 32'h000000FF, 32'h000000A5, 3, 5, 60, 58, -1);

      // Edge trigger on bit0 after ten quiet strobes
      for (int e = 0; e <= MAXE; e++) begin
         probe_a[e] = {31'($urandom), (e >= 21) ? 1'b1 : 1'b0};
         full_a[e] = 0;
      end
      run_scn(3, 2'd2, 32'h1, 32'h0, 1, 3, 40, 38, -1);

      // Overflow on capture strobes 3-5
      for (int e = 0; e <= MAXE; e++) begin
         probe_a[e] = $urandom;
         full_a[e] = (e >= 4) && (e <= 6);
      end
      run_scn(4, 2'd0, 32'h0, 32'h0, 0, 8, 16, 14, -1);
      chk("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
      chk("ovf_flag", 32'(overflow), 32'd1);

      // Abort mid continuous capture with random full
      for (int e = 0; e <= MAXE; e++) begin
         probe_a[e] = $urandom;
         full_a[e] = ($urandom_range(0, 3) == 0);
      end
      run_scn(5, 2'd0, 32'h0, 32'h0, 1, 0, 40, 25, -1);
      chk("abort_trig", 32'(triggered), 32'd0);
      chk("abort_drop_kept", 32'(drop_cnt), 32'(g_drops));

      // Zero mask: edge mode never fires, level mode fires at once
      for (int e = 0; e <= MAXE; e++) begin probe_a[e] = $urandom; full_a[e] = 0; end
      run_scn(6, 2'd2, 32'h0, 32'h0, 0, 2, 30, 28, -1);
      run_scn(7, 2'd1, 32'h0, $urandom, 2, 3, 30, 28, -1);

      // Randomised scenarios
      for (int i = 0; i < 14; i++) begin
         div = $urandom_range(0, 4);
         len = $urandom_range(0, 12);
         case ($urandom_range(0, 3))
            0:       m = 32'hFFFFFFFF;
            1:       m = 32'h000000FF;
            2:       m = 32'h00000001 << $urandom_range(0, 31);
            default: m = $urandom;
         endcase
         v = sym();
         for (int e = 0; e <= MAXE; e++) begin
            probe_a[e] = ($urandom_range(0, 7) == 0) ? $urandom : sym();
            full_a[e] = ($urandom_range(0, 4) == 0);
         end
         ne = 4 + (div + 1) * (len + 10);
         run_scn(10 + i, 2'($urandom_range(0, 3)), m, v, div, len, ne, ne - 2, -1);
      end

      // Asynchronous reset while a push is on the port
      for (int e = 0; e <= MAXE; e++) begin probe_a[e] = $urandom | 32'h1; full_a[e] = 0; end
      run_scn(30, 2'd0, 32'h0, 32'h0, 0, 0, 20, 20, 6);
      run_scn(31, 2'd0, 32'h0, 32'h0, 0, 3, 12, 10, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/la_capture.md
# la_capture

Probe capture stage of the logic analyzer. It synchronises the 32-bit probe bus, decimates it with a programmable sample divider, waits for a trigger, then pushes samples into the capture FIFO that the FT601 FIFO state machine drains. It also accounts for samples dropped while the FIFO is full.

## Interface
Parameters:
- DATA_LEN, 32, probe / sample width
- DIV_LEN, 16, sample divider width
- CNT_LEN, 24, capture length counter width

Ports:
- clk  in  1  sampling clock; all flops on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run_en  in  1  capture enable from command path (START/STOP)
- probe_in  in  DATA_LEN  asynchronous probe pins
- sample_div  in  DIV_LEN  sample strobe every sample_div+1 clocks
- capture_len  in  CNT_LEN  samples to capture after trigger; 0 = continuous
- trig_mode  in  2  0 immediate, 1 level match, 2 edge, 3 treated as 0
- trig_mask  in  DATA_LEN  bits participating in trigger
- trig_value  in  DATA_LEN  level-match value
- full_fifo  in  1  capture FIFO full
- fifo_data  out  DATA_LEN  sample word to FIFO
- fifo_push_n  out  1  active-low one-cycle FIFO write strobe
- overflow  out  1  sticky; set on first dropped sample
- drop_cnt  out  16  dropped-sample count, saturating at 16'hFFFF
- triggered  out  1  high from trigger until return to IDLE
- done  out  1  high in DONE

## Operation
- Probe path: 2-flop synchroniser (sync2), then sample register prev holding the previous strobed sample.
- Divider: counter reloads to sample_div, decrements every clk while state != IDLE. strobe = (counter == 0). sample_div = 0 gives a strobe every clk.
- Configuration (sample_div, capture_len, trig_*) is latched on IDLE->ARMED and is ignored afterwards.
- State machine:
  - IDLE: run_en=1 -> ARMED. On entry, clears the divider, the sample count, and prev_valid.
  - ARMED: on a strobe, evaluates the trigger on sync2. A hit -> CAPTURE, and that same sample is the first one captured. Without a hit, prev <= sync2 and prev_valid <= 1.
  - CAPTURE: on each strobe, attempts a push of sync2 and increments the sample count. When capture_len != 0 and the count reaches capture_len -> DONE.
  - DONE: holds, with no pushes, until run_en=0.
  - From any state, run_en=0 -> IDLE on the next clk. A push already registered for that cycle still completes. No new push is issued.
- Trigger conditions:
  - Mode 0: hit on the first strobe.
  - Mode 1: hit when (sync2 & mask) == (value & mask).
  - Mode 2: hit when prev_valid && ((sync2 ^ prev) & mask) != 0.
  - mask = 0 in modes 1 and 2: mode 1 hits immediately; mode 2 never hits.
- Full handling: a push attempted while full_fifo=1 is dropped. drop_cnt increments (saturating) and overflow is set. The sample still counts toward capture_len.
- overflow and drop_cnt clear only on reset or IDLE->ARMED. They persist through DONE and IDLE so the host can read them.
- Sample count width is CNT_LEN. In continuous mode it wraps with no effect.

## Timing
- Reset values:
  - fifo_data = 0, fifo_push_n = 1, overflow = 0, drop_cnt = 0, triggered = 0, done = 0.
  - state = IDLE, divider = 0, prev = 0, prev_valid = 0.
- Pin-to-sample latency: 2 clk (synchroniser).
- Push timing: fifo_data and fifo_push_n are registered.
  - The push asserts in the clk after the strobe, for exactly 1 clk.
  - fifo_data is stable while fifo_push_n = 0 and holds its value afterwards.
- full_fifo is sampled in the strobe cycle, not the push cycle.
- triggered rises in the same clk as the first push.
- done rises 1 clk after the last push strobe.
- The first strobe comes sample_div+1 clks after entering ARMED.
- Push rate is at most 1 per clk (sample_div = 0).

## Test plan
- Immediate capture:
  - Stimulus: mode 0, sample_div=0, capture_len=4, counting probe bus, full_fifo=0.
  - Required: exactly 4 consecutive fifo_push_n pulses carrying consecutive values; done=1; drop_cnt=0.
- Level trigger with decimation:
  - Stimulus: mode 1, mask=32'h000000FF, value=32'h000000A5, sample_div=3, probe ramps through 0xA5 in bits [7:0].
  - Required: the first push data has [7:0]=0xA5; pushes are spaced 4 clks apart.
- Edge trigger:
  - Stimulus: mode 2, mask=32'h1, bit0 held 0 for 10 strobes, then goes 1.
  - Required: no push before the change; the first pushed word has bit0=1.
- Overflow:
  - Stimulus: capture_len=8, full_fifo=1 during strobes 3-5.
  - Required: 5 pushes; drop_cnt=3; overflow=1; done after 8 strobes.
- Abort mid-capture:
  - Stimulus: run_en drops during CAPTURE.
  - Required: IDLE next clk; no further pushes; triggered=0; drop_cnt retained.
- Reset mid-operation:
  - Stimulus: rst_n low during CAPTURE with fifo_push_n=0.
  - Required: fifo_push_n=1 immediately (asynchronous); all outputs at their reset values.
